// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, slice selects,
// controller state encoding and the decoded control bundle.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_SLT  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    localparam logic [1:0] SEL_ADDSUB = 2'd0;
    localparam logic [1:0] SEL_XOR    = 2'd1;
    localparam logic [1:0] SEL_SLT    = 2'd2;
    localparam logic [1:0] SEL_LOGIC  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] sel;
        logic       use_or;
        logic       invflag;
    } alu_ctrl_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational map from a 3-bit opcode onto the ALU slice controls.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0] op,
    output logic [1:0] sel,
    output logic       use_or,
    output logic       invflag
);

    alu_ctrl_t ctrl_s;

    // opcode to slice select / or-slice / invert decode
    always_comb begin
        ctrl_s = '{sel: SEL_ADDSUB, use_or: 1'b0, invflag: 1'b0};
        case (op)
            OP_ADD:  ctrl_s = '{sel: SEL_ADDSUB, use_or: 1'b0, invflag: 1'b0};
            OP_SUB:  ctrl_s = '{sel: SEL_ADDSUB, use_or: 1'b0, invflag: 1'b1};
            OP_XOR:  ctrl_s = '{sel: SEL_XOR,    use_or: 1'b0, invflag: 1'b0};
            OP_SLT:  ctrl_s = '{sel: SEL_SLT,    use_or: 1'b0, invflag: 1'b1};
            OP_AND:  ctrl_s = '{sel: SEL_LOGIC,  use_or: 1'b0, invflag: 1'b0};
            OP_NAND: ctrl_s = '{sel: SEL_LOGIC,  use_or: 1'b0, invflag: 1'b1};
            OP_NOR:  ctrl_s = '{sel: SEL_LOGIC,  use_or: 1'b1, invflag: 1'b1};
            OP_OR:   ctrl_s = '{sel: SEL_LOGIC,  use_or: 1'b1, invflag: 1'b0};
            default: ctrl_s = '{sel: SEL_ADDSUB, use_or: 1'b0, invflag: 1'b0};
        endcase
    end

    assign sel     = ctrl_s.sel;
    assign use_or  = ctrl_s.use_or;
    assign invflag = ctrl_s.invflag;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: accepts a command, holds the
// operands steady while the gate-delayed ALU settles, then captures a response.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    output logic             alu_or,
    output logic             alu_invflag,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carryout,
    output logic             rsp_overflow,
    output logic             rsp_zero
);

    // Counter starts one below the settle time so capture lands exactly
    // SETTLE_CYCLES edges after the accept edge.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_sel_q, alu_sel_d;
    logic             alu_or_q, alu_or_d;
    logic             alu_invflag_q, alu_invflag_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_carryout_q, rsp_carryout_d;
    logic             rsp_overflow_q, rsp_overflow_d;
    logic             rsp_zero_q, rsp_zero_d;

    logic [1:0]       dec_sel_s;
    logic             dec_or_s;
    logic             dec_inv_s;

    alu_op_decode u_decode (
        .op      (cmd_op),
        .sel     (dec_sel_s),
        .use_or  (dec_or_s),
        .invflag (dec_inv_s)
    );

    // next-state and next-output computation for the issue FSM
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cmd_ready_d    = cmd_ready_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_sel_d      = alu_sel_q;
        alu_or_d       = alu_or_q;
        alu_invflag_d  = alu_invflag_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_result_d   = rsp_result_q;
        rsp_carryout_d = rsp_carryout_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_zero_d     = rsp_zero_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    alu_a_d       = cmd_a;
                    alu_b_d       = cmd_b;
                    alu_sel_d     = dec_sel_s;
                    alu_or_d      = dec_or_s;
                    alu_invflag_d = dec_inv_s;
                    cnt_d         = SETTLE_LOAD;
                    cmd_ready_d   = 1'b0;
                    state_d       = SETTLE;
                end else begin
                    cmd_ready_d   = 1'b1;
                    state_d       = IDLE;
                end
            end
            SETTLE: begin
                cmd_ready_d = 1'b0;
                if (cnt_q == 4'd0) begin
                    rsp_result_d   = alu_result;
                    rsp_carryout_d = alu_carryout;
                    rsp_overflow_d = alu_overflow;
                    rsp_zero_d     = (alu_result == {WIDTH{1'b0}});
                    rsp_valid_d    = 1'b1;
                    state_d        = RESP;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = SETTLE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = RESP;
                end
            end
            default: begin
                // unused encoding: recover to a clean idle without a response
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b0;
                cnt_d       = 4'd0;
                state_d     = IDLE;
            end
        endcase
    end

    // state and registered-output flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            cmd_ready_q    <= 1'b0;
            alu_a_q        <= {WIDTH{1'b0}};
            alu_b_q        <= {WIDTH{1'b0}};
            alu_sel_q      <= 2'd0;
            alu_or_q       <= 1'b0;
            alu_invflag_q  <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= {WIDTH{1'b0}};
            rsp_carryout_q <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_zero_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cmd_ready_q    <= cmd_ready_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_sel_q      <= alu_sel_d;
            alu_or_q       <= alu_or_d;
            alu_invflag_q  <= alu_invflag_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_carryout_q <= rsp_carryout_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_zero_q     <= rsp_zero_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_sel      = alu_sel_q;
    assign alu_or       = alu_or_q;
    assign alu_invflag  = alu_invflag_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_carryout = rsp_carryout_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_zero     = rsp_zero_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl with a slice-level ALU
// model on the datapath side and an opcode-level reference for responses.
module tb_alu_issue_ctrl;

    localparam int SC = 4;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_sel;
    logic        alu_or;
    logic        alu_invflag;
    logic [31:0] alu_result;
    logic        alu_carryout;
    logic        alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_carryout;
    logic        rsp_overflow;
    logic        rsp_zero;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] e_res;
    logic        e_c;
    logic        e_v;
    logic [31:0] e_a;

    alu_issue_ctrl #(.WIDTH(32), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_or(alu_or),
        .alu_invflag(alu_invflag), .alu_result(alu_result),
        .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carryout(rsp_carryout), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU slices: adder with b-invert, xor, slt via subtract, and/or with invert.
    // Logic slices present parity bits on carry/overflow so pass-through is visible.
    logic [31:0] m_bx;
    logic [32:0] m_sum;
    logic        m_ovf;
    logic [31:0] m_log;
    always_comb begin
        m_bx  = alu_b ^ {32{alu_invflag}};
        m_sum = {1'b0, alu_a} + {1'b0, m_bx} + {32'd0, alu_invflag};
        m_ovf = (alu_a[31] == m_bx[31]) && (m_sum[31] != alu_a[31]);
        m_log = alu_or ? (alu_a | alu_b) : (alu_a & alu_b);
        case (alu_sel)
            2'd0: begin alu_result = m_sum[31:0]; alu_carryout = m_sum[32]; alu_overflow = m_ovf; end
            2'd1: begin alu_result = alu_a ^ alu_b; alu_carryout = ^alu_a; alu_overflow = ^alu_b; end
            2'd2: begin alu_result = {31'd0, m_sum[31] ^ m_ovf}; alu_carryout = m_sum[32]; alu_overflow = m_ovf; end
            default: begin alu_result = m_log ^ {32{alu_invflag}}; alu_carryout = ^alu_a; alu_overflow = ^alu_b; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Opcode-level reference: {overflow, carry, result}
    function automatic logic [33:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c;
        logic        v;
        r = 32'd0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                        v = (a[31] == b[31]) && (r[31] != a[31]); end
            3'd1: begin r = a - b; c = (a >= b); v = (a[31] != b[31]) && (r[31] != a[31]); end
            3'd2: begin r = a ^ b; c = ^a; v = ^b; end
            3'd3: begin w = {1'b0, a - b}; c = (a >= b); v = (a[31] != b[31]) && (w[31] != a[31]);
                        r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
            3'd4: begin r = a & b;    c = ^a; v = ^b; end
            3'd5: begin r = ~(a & b); c = ^a; v = ^b; end
            3'd6: begin r = ~(a | b); c = ^a; v = ^b; end
            default: begin r = a | b; c = ^a; v = ^b; end
        endcase
        return {v, c, r};
    endfunction

    function automatic logic [3:0] exp_dec(input logic [2:0] op);
        // {sel[1:0], or, inv}
        case (op)
            3'd0: return 4'b00_0_0;
            3'd1: return 4'b00_0_1;
            3'd2: return 4'b01_0_0;
            3'd3: return 4'b10_0_1;
            3'd4: return 4'b11_0_0;
            3'd5: return 4'b11_0_1;
            3'd6: return 4'b11_1_1;
            default: return 4'b11_1_0;
        endcase
    endfunction

    task automatic accept_check(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [3:0] d;
        d = exp_dec(op);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("acc_ready", 32'(cmd_ready), 32'd0);
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        chk("alu_sel", 32'(alu_sel), 32'(d[3:2]));
        chk("alu_or", 32'(alu_or), 32'(d[1]));
        chk("alu_inv", 32'(alu_invflag), 32'(d[0]));
    endtask

    task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        accept_check(op, a, b);
    endtask

    task automatic wait_rsp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        bit got;
        logic [33:0] e;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                chk("settle_ready", 32'(cmd_ready), 32'd0);
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 3'($urandom_range(0, 7));
                cmd_a     = $urandom();
                cmd_b     = $urandom();
                rsp_ready = 1'($urandom_range(0, 1));
            end
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("latency", 32'(lat), 32'(SC));
        e = ref_op(op, a, b);
        e_res = e[31:0]; e_c = e[32]; e_v = e[33]; e_a = a;
        chk("rsp_result", rsp_result, e_res);
        chk("rsp_carry", 32'(rsp_carryout), 32'(e_c));
        chk("rsp_ovf", 32'(rsp_overflow), 32'(e_v));
        chk("rsp_zero", 32'(rsp_zero), 32'(e_res == 32'd0));
        chk("alu_a_held", alu_a, a);
        chk("alu_b_held", alu_b, b);
    endtask

    task automatic release_rsp(input int hold, input bit keep_valid);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_result", rsp_result, e_res);
            chk("hold_flags", 32'({rsp_carryout, rsp_overflow}), 32'({e_c, e_v}));
            chk("hold_ready", 32'(cmd_ready), 32'd0);
            chk("hold_alu_a", alu_a, e_a);
        end
        rsp_ready = 1'b1;
        if (!keep_valid) cmd_valid = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rel_valid", 32'(rsp_valid), 32'd0);
        chk("rel_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 32'd0; cmd_b = 32'd0; rsp_ready = 1'b0;
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_held", 32'(cmd_ready), 32'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);

        // AND / NAND / zero / ADD overflow
        start(3'd4, 32'hF0F0F0F0, 32'hFF00FF00);
        wait_rsp(3'd4, 32'hF0F0F0F0, 32'hFF00FF00);
        chk("and_value", rsp_result, 32'hF000F000);
        chk("and_zero", 32'(rsp_zero), 32'd0);
        release_rsp(1, 1'b0);
        start(3'd5, 32'hF0F0F0F0, 32'hFF00FF00);
        wait_rsp(3'd5, 32'hF0F0F0F0, 32'hFF00FF00);
        chk("nand_value", rsp_result, 32'h0FFF0FFF);
        release_rsp(0, 1'b0);
        start(3'd4, 32'hAAAAAAAA, 32'h55555555);
        wait_rsp(3'd4, 32'hAAAAAAAA, 32'h55555555);
        chk("zero_flag", 32'(rsp_zero), 32'd1);
        release_rsp(2, 1'b0);
        start(3'd0, 32'h7FFFFFFF, 32'h00000001);
        wait_rsp(3'd0, 32'h7FFFFFFF, 32'h00000001);
        chk("add_value", rsp_result, 32'h80000000);
        chk("add_ovf", 32'({rsp_overflow, rsp_carryout}), 32'b10);
        release_rsp(0, 1'b0);

        // backpressure with a competing command held valid
        start(3'd2, 32'h12345678, 32'h0F0F0F0F);
        wait_rsp(3'd2, 32'h12345678, 32'h0F0F0F0F);
        cmd_valid = 1'b1; cmd_op = 3'd7; cmd_a = 32'hA5A50000; cmd_b = 32'h00005A5A;
        release_rsp(10, 1'b1);
        accept_check(3'd7, 32'hA5A50000, 32'h00005A5A);
        wait_rsp(3'd7, 32'hA5A50000, 32'h00005A5A);
        release_rsp(0, 1'b0);

        // reset while the counter is at 2
        start(3'd0, 32'h11111111, 32'h22222222);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_alu_b", alu_b, 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_ready_up", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < SC + 2; i++) begin
            @(posedge clk); #1;
            chk("dropped_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // randomized commands
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom();
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom();
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            start(op, a, b);
            wait_rsp(op, a, b);
            release_rsp($urandom_range(0, 3), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential front-end that drives the combinational 32-bit ALU slices (add/sub, xor, slt, and/nand, nor/or) and captures their results.
- Accepts one command through a valid/ready handshake and drives operands, op select and invert flag onto the ALU.
- Waits a fixed number of clocks for the gate-delayed ALU outputs to settle, then registers result and flags into a valid/ready response.
- Sits between the CPU/testbench command source and the ALU datapath.

Parameters:
- WIDTH, 32, operand/result width.
- SETTLE_CYCLES, 4, clock edges between driving operands and capturing ALU outputs; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- alu_a  out  WIDTH  registered operand A to the ALU.
- alu_b  out  WIDTH  registered operand B to the ALU.
- alu_sel  out  2  slice select: 0 add/sub, 1 xor, 2 slt, 3 and/nand, with or/nor also on 3 via alu_or.
- alu_or  out  1  1 selects the or/nor slice instead of and/nand.
- alu_invflag  out  1  slice invert/subtract flag: 1 gives SUB, NAND or NOR.
- alu_result  in  WIDTH  ALU output.
- alu_carryout  in  1  ALU carry out.
- alu_overflow  in  1  ALU overflow.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  WIDTH  captured result.
- rsp_carryout  out  1  captured carry out.
- rsp_overflow  out  1  captured overflow.
- rsp_zero  out  1  1 when captured result == 0.

Behaviour:
- Reset (async, active-high): state IDLE, counter 0, every output 0 except cmd_ready. cmd_ready is 0 while reset is asserted and 1 from the first clk edge after deassert.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready at edge N: register cmd_a/cmd_b onto alu_a/alu_b, decode cmd_op into alu_sel/alu_or/alu_invflag, load counter with SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: cmd_ready=0. Counter decrements each edge. At the edge where counter==0 (edge N+SETTLE_CYCLES): capture alu_result/carryout/overflow into rsp_*, compute rsp_zero from the captured result, set rsp_valid=1, go to RESP.
  - RESP: rsp_valid=1 and all rsp_* held stable. On rsp_ready at edge M: rsp_valid=0, go to IDLE. cmd_ready=1 from edge M.
- Latency: accept edge to rsp_valid is exactly SETTLE_CYCLES edges.
- Throughput: at most one command per SETTLE_CYCLES+2 cycles; no overlap and no command queueing.
- Decode:
  - ADD: sel0, inv0. SUB: sel0, inv1.
  - XOR: sel1, inv0. SLT: sel2, inv1 (subtract).
  - AND: sel3, or0, inv0. NAND: sel3, or0, inv1.
  - NOR: sel3, or1, inv1. OR: sel3, or1, inv0.
- Logic and SLT results pass through unmodified; carryout and overflow are captured for every op as presented by the ALU.
- alu_* outputs hold their last values after the response; they are not cleared.
- cmd_valid outside IDLE is ignored; the block never accepts during SETTLE or RESP.
- rsp_ready while rsp_valid=0 has no effect.
- Reset mid-SETTLE or mid-RESP drops the in-flight command; no response is produced.
- A cmd_op change while cmd_valid is high but not accepted has no effect.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD..OP_OR (3-bit);
  - slice select constants SEL_ADDSUB, SEL_XOR, SEL_SLT, SEL_LOGIC;
  - state encoding IDLE/SETTLE/RESP (2-bit).
- One natural sub-module: alu_op_decode, a combinational map from cmd_op to {alu_sel, alu_or, alu_invflag}. It is reused by the ALU top-level testbench.

Test Plan:
- AND, SETTLE_CYCLES=4: cmd_op=4, a=0xF0F0F0F0, b=0xFF00FF00 -> alu_sel=3, alu_or=0, alu_invflag=0; rsp_result=0xF000F000, rsp_zero=0; rsp_valid rises exactly 4 edges after accept.
- NAND with the same operands, op=5 -> alu_invflag=1, rsp_result=0x0FFF0FFF.
- Zero flag: op=4, a=0xAAAAAAAA, b=0x55555555 -> rsp_result=0, rsp_zero=1.
- ADD overflow: op=0, a=0x7FFFFFFF, b=1 -> rsp_result=0x80000000, overflow=1, carryout=0.
- Backpressure: hold rsp_ready=0 for 10 cycles with cmd_valid=1 and a new command -> rsp_* stable, cmd_ready=0, second command not accepted; accepted 1 edge after rsp_ready.
- Reset at SETTLE count 2 -> all outputs 0 immediately, rsp_valid never asserts for that command, cmd_ready=1 one edge after deassert.
